rv32i_mem_arbiter: RTL
======================

Name: rv32i_mem_arbiter

Overview:
- Shares one Avalon-MM style memory port between the RV32I core's instruction-fetch bus and data (load/store) bus.
- Sits between the core top level and a unified instruction/data memory.
- Fixed priority with a configurable burst limit, so the lower-priority side is never starved.
- One outstanding transaction at a time; the requester's request is held until its waitrequest drops.

Parameters:
- PRIO_DATA, 1: 1 = data side has priority, 0 = instruction side has priority.
- MAX_BURST, 4: consecutive priority-side grants allowed while the other side is pending; 0 disables the limit; range 0..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iaddress  in  32  instruction read address
- iread  in  1  instruction read request
- ireaddata  out  32  instruction read data, valid when iwaitrequest is low
- iwaitrequest  out  1  low for exactly the completion cycle of an instruction read
- daddress  in  32  data address
- dread  in  1  data read request
- dwrite  in  1  data write request
- dwritedata  in  32  write data
- dbyteenable  in  4  write byte enables
- dreaddata  out  32  data read data, valid when dwaitrequest is low
- dwaitrequest  out  1  low for exactly the completion cycle of a data access
- m_address  out  32  memory address
- m_read  out  1  memory read command
- m_write  out  1  memory write command
- m_writedata  out  32  memory write data
- m_byteenable  out  4  memory byte enables
- m_readdata  in  32  memory read data
- m_waitrequest  in  1  memory command stall
- m_readdatavalid  in  1  memory read data valid

Behaviour:
- Reset (synchronous, active-high, takes effect at the clock edge):
  - State goes to IDLE; burst counter = 0.
  - m_read = m_write = 0; m_address, m_writedata = 0; m_byteenable = 4'hF.
  - iwaitrequest = dwaitrequest = 1; ireaddata = dreaddata = 0.
- States:
  - IDLE
  - I_CMD, I_RD
  - D_CMD, D_RD
- IDLE arbitration:
  - A data request is dread | dwrite.
  - Only one side requesting: that side is granted.
  - Both requesting: the priority side is granted, unless MAX_BURST != 0 and the counter has reached MAX_BURST; then the other side is granted.
- Burst counter:
  - Increments on each priority-side grant made while the other side is requesting.
  - Clears on any non-priority-side grant.
  - Clears on an IDLE cycle with no request.
  - Saturates at 255.
- On grant, the command fields are registered and held stable until accepted:
  - Instruction grant: iaddress -> m_address, byteenable 4'hF, m_read = 1.
  - Data write (dwrite = 1): m_address, m_writedata, m_byteenable from the data bus; m_write = 1.
  - Data read: m_read = 1, byteenable 4'hF.
  - dread and dwrite both asserted: performed as a write.
- x_CMD state:
  - Holds the command while m_waitrequest = 1.
  - When m_waitrequest = 0, m_read/m_write deassert at the next edge.
  - Read: move to x_RD.
  - Write: dwaitrequest = 0 (combinational) in this accept cycle, then IDLE.
- x_RD state:
  - Waits for m_readdatavalid.
  - In that cycle, m_readdata passes combinationally to ireaddata/dreaddata and the matching waitrequest = 0; then IDLE.
- Latency:
  - Grant edge, then a 1-cycle minimum command phase, then memory read latency, then completion.
  - Minimum 3 clocks per transaction from request seen in IDLE to the next arbitration.
- A requester that deasserts its request mid-transaction: the transaction still completes; its waitrequest still pulses low; the data is discarded.
- m_readdatavalid outside I_RD/D_RD is ignored.
- Reset asserted in any state aborts the transaction immediately; a late m_readdatavalid after reset is ignored.
- Read data outputs hold their last value when not completing.

Test Plan:
- I-read only: iread = 1, iaddress = 0x100; memory accepts at once and returns 0x00000013 two cycles later -> m_read for 1 cycle with m_address 0x100; iwaitrequest low exactly one cycle with ireaddata = 0x00000013.
- Simultaneous requests, PRIO_DATA = 1: dwrite to 0x2000, data 0xDEADBEEF, BE 4'b0100, plus iread 0x104 -> write issued first with m_byteenable 4'b0100 and dwaitrequest low on accept; the instruction read is then issued with BE 4'hF.
- Starvation, MAX_BURST = 4: dread held continuously with iread pending -> 4 data grants, 5th grant goes to instruction, then data resumes; with MAX_BURST = 0, the instruction side waits until dread drops.
- Command stall: m_waitrequest held high 3 cycles during a data write -> m_address, m_writedata, m_byteenable and m_write constant for all 4 cycles; dwaitrequest low only in the 4th.
- Reset in D_RD: reset pulsed while awaiting read data, then m_readdatavalid asserted -> all outputs at reset values, no waitrequest pulse, state IDLE.
- PRIO_DATA = 0 with simultaneous requests -> instruction granted first; data access follows.

Source files
------------

// File: rtl/rv32i_mem_arbiter.sv
// rv32i_mem_arbiter: shares one Avalon-MM memory port between instruction fetch and data buses.
// Fixed priority with a burst limit so the lower-priority side cannot starve.
module rv32i_mem_arbiter #(
    parameter int PRIO_DATA = 1,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iaddress,
    input  logic        iread,
    output logic [31:0] ireaddata,
    output logic        iwaitrequest,
    input  logic [31:0] daddress,
    input  logic        dread,
    input  logic        dwrite,
    input  logic [31:0] dwritedata,
    input  logic [3:0]  dbyteenable,
    output logic [31:0] dreaddata,
    output logic        dwaitrequest,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] I_CMD = 3'd1;
    localparam logic [2:0] I_RD  = 3'd2;
    localparam logic [2:0] D_CMD = 3'd3;
    localparam logic [2:0] D_RD  = 3'd4;
    localparam logic       PD    = PRIO_DATA != 0;
    localparam logic [7:0] MB    = 8'(MAX_BURST);

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] m_address_q, m_address_d, m_writedata_q, m_writedata_d;
    logic [31:0] ireaddata_q, ireaddata_d, dreaddata_q, dreaddata_d;
    logic [3:0]  m_byteenable_q, m_byteenable_d;
    logic        m_read_q, m_read_d, m_write_q, m_write_d;
    logic        dreq, both, limit, grant_prio, grant_data, grant_wr;
    logic        i_done, d_rd_done, d_done;

    always_comb begin
        dreq       = dread | dwrite;
        both       = iread & dreq;
        limit      = (MB != 8'd0) && (cnt_q >= MB);
        grant_prio = (PD ? dreq : iread) && !(both && limit);
        grant_data = PD ? grant_prio : (dreq && !grant_prio);
        grant_wr   = grant_data & dwrite;
        i_done     = !reset && state_q == I_RD && m_readdatavalid;
        d_rd_done  = !reset && state_q == D_RD && m_readdatavalid;
        d_done     = d_rd_done || (!reset && state_q == D_CMD && m_write_q && !m_waitrequest);
        state_d        = state_q;
        cnt_d          = cnt_q;
        m_address_d    = m_address_q;
        m_writedata_d  = m_writedata_q;
        m_byteenable_d = m_byteenable_q;
        m_read_d       = m_read_q;
        m_write_d      = m_write_q;
        ireaddata_d    = i_done ? m_readdata : ireaddata_q;
        dreaddata_d    = d_rd_done ? m_readdata : dreaddata_q;
        case (state_q)
            IDLE: begin
                if (iread | dreq) begin
                    state_d        = grant_data ? D_CMD : I_CMD;
                    // burst count only grows while the other side is actually waiting
                    cnt_d          = !grant_prio ? 8'd0 : !both ? cnt_q : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    m_address_d    = grant_data ? daddress : iaddress;
                    m_writedata_d  = grant_wr ? dwritedata : m_writedata_q;
                    m_byteenable_d = grant_wr ? dbyteenable : 4'hF;
                    m_read_d       = !grant_wr;
                    m_write_d      = grant_wr;
                end else begin
                    cnt_d = 8'd0;
                end
            end
            I_CMD, D_CMD: begin
                if (!m_waitrequest) begin
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                    state_d   = m_write_q ? IDLE : (state_q == I_CMD) ? I_RD : D_RD;
                end
            end
            I_RD, D_RD: state_d = m_readdatavalid ? IDLE : state_q;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 8'd0;
            m_address_q    <= 32'd0;
            m_writedata_q  <= 32'd0;
            m_byteenable_q <= 4'hF;
            m_read_q       <= 1'b0;
            m_write_q      <= 1'b0;
            ireaddata_q    <= 32'd0;
            dreaddata_q    <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            m_address_q    <= m_address_d;
            m_writedata_q  <= m_writedata_d;
            m_byteenable_q <= m_byteenable_d;
            m_read_q       <= m_read_d;
            m_write_q      <= m_write_d;
            ireaddata_q    <= ireaddata_d;
            dreaddata_q    <= dreaddata_d;
        end
    end

    assign m_address    = m_address_q;
    assign m_writedata  = m_writedata_q;
    assign m_byteenable = m_byteenable_q;
    assign m_read       = m_read_q;
    assign m_write      = m_write_q;
    assign iwaitrequest = !i_done;
    assign dwaitrequest = !d_done;
    assign ireaddata    = i_done ? m_readdata : ireaddata_q;
    assign dreaddata    = d_rd_done ? m_readdata : dreaddata_q;
endmodule
